// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// the bit-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Counter must hold the value W, so it needs clog2(W+1) bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (W+1)-bit trial subtraction a - b; the borrow is the MSB of the
// full-width difference.
module div_trial_sub #(
  parameter int unsigned W = 5
) (
  input  logic [W:0]   a_i,
  input  logic [W:0]   b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] full;

  assign full     = a_i - b_i;
  assign diff_o   = full[W-1:0];
  assign borrow_o = full[W];

endmodule

// File: rtl/div_seq_restore.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes. Optional divide-by-zero fast path: DIV_DZ_EN.
module div_seq_restore
  import div_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
`ifdef DIV_DZ_EN
  output logic [W-1:0] rem,
  output logic         dz
`else
  output logic [W-1:0] rem
`endif
);

  localparam int unsigned CW = cnt_width(W);

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  pr_q, pr_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    pr_shift;
  logic [W-1:0]  diff;
  logic          borrow;

  assign pr_shift = {pr_q, q_q[W-1]};

  div_trial_sub #(
    .W(W)
  ) u_sub (
    .a_i     (pr_shift),
    .b_i     ({1'b0, dvsr_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

`ifdef DIV_DZ_EN
  logic dz_q, dz_d;
  assign dz = dz_q;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    pr_d    = pr_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
`ifdef DIV_DZ_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dvsr_d  = divisor;
          q_d     = dividend;
          pr_d    = '0;
          cnt_d   = CW'(W);
          state_d = StRun;
`ifdef DIV_DZ_EN
          if (divisor == '0) begin
            q_d     = '1;
            pr_d    = dividend;
            cnt_d   = '0;
            dz_d    = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        // Count reaching zero costs one extra cycle before DONE (latency W+1).
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
          q_d   = {q_q[W-2:0], ~borrow};
          // On borrow pr_shift[W] is always 0, so W bits hold the restored value.
          pr_d  = borrow ? pr_shift[W-1:0] : diff;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
`ifdef DIV_DZ_EN
          dz_d    = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      pr_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
`ifdef DIV_DZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pr_q    <= pr_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
`ifdef DIV_DZ_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quot      = q_q;
  assign rem       = pr_q;

endmodule

// File: tb/tb_div_seq_restore.sv
// Self-checking bench for div_seq_restore: directed cases, stall/reset cases and
// randomized back-to-back operations against an arithmetic reference model.
module tb_div_seq_restore;

  localparam int unsigned W = 5;
  localparam int unsigned AllOnes = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
`ifdef DIV_DZ_EN
  logic         dz;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_seq_restore #(
    .W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
`ifdef DIV_DZ_EN
    .rem      (rem),
    .dz       (dz)
`else
    .rem      (rem)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned division; zero divisor gives all ones / dividend.
  function automatic int ref_quot(input int a, input int b);
    return (b == 0) ? AllOnes : a / b;
  endfunction

  function automatic int ref_rem(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input int b);
`ifdef DIV_DZ_EN
    if (b == 0) return 0;  // valid on the accepting edge itself
`endif
    return W + 1;
  endfunction

  // Issue one op, check result/latency, hold it for 'stall' cycles while poking
  // in_valid, then complete the handshake.
  task automatic run_op(input int a, input int b, input int stall);
    int g;
    int lat;
    int q0;
    int r0;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", int'(g < 50), 1);
    in_valid = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid", int'(out_valid), 1);
    check("latency", lat, ref_lat(b));
    check("quot", int'(quot), ref_quot(a, b));
    check("rem", int'(rem), ref_rem(a, b));
`ifdef DIV_DZ_EN
    check("dz", int'(dz), int'(b == 0));
`endif
    q0 = int'(quot);
    r0 = int'(rem);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'(i % 2 == 0);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      #1;
      check("stall_valid", int'(out_valid), 1);
      check("stall_ready", int'(in_ready), 0);
      check("stall_quot", int'(quot), q0);
      check("stall_rem", int'(rem), r0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_ready", int'(in_ready), 1);
  endtask

  initial begin
    int a;
    int b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quot", int'(quot), 0);
    check("rst_rem", int'(rem), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(27, 4, 0);
    run_op(31, 1, 0);
    run_op(3, 7, 0);
    run_op(31, 31, 0);
    run_op(0, 5, 0);
    run_op(13, 0, 0);
    run_op(27, 4, 4);  // long stall with ignored in_valid pulses

    // Reset during the 3rd RUN cycle of 27/4.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = W'(27);
    divisor  = W'(4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_quot", int'(quot), 0);
    check("midrst_rem", int'(rem), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_result", int'(out_valid), 0);
    end
    run_op(20, 3, 0);

    // Randomized back-to-back operations with random result stalls.
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, AllOnes));
      b = (k % 8 == 3) ? 0 : int'($urandom_range(0, AllOnes));
      run_op(a, b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
